// File: rtl/rom_seq_reader_pkg.sv
// Shared constants for the ROM sequential reader: bus widths, ROM depth,
// FSM state encoding and the address wrap helper.
package rom_seq_reader_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 4;
   localparam int DEPTH  = 8;
   localparam int LEN_W  = 4;
   localparam int SUM_W  = DATA_W + LEN_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Next ROM address, wrapping from the last populated entry back to 0.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/rom_seq_reader.sv
// ROM address sequencer and stream stage. A start command sweeps len
// consecutive ROM addresses from base_addr (wrapping at DEPTH), registers
// each combinational ROM word into a valid/ready stream and keeps a running
// sum of emitted words.
module rom_seq_reader
   import rom_seq_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic              err,
   output logic [SUM_W-1:0]  sum
);

   // Unsigned accumulate of one ROM word; wraps at the sum width.
   function automatic logic [SUM_W-1:0] acc_word(input logic [SUM_W-1:0] s,
                                                 input logic [DATA_W-1:0] w);
      return s + {{LEN_W{1'b0}}, w};
   endfunction

   logic [1:0]       state;
   logic [LEN_W-1:0] remaining;
   logic             load;

   // The output register can take a new word when empty or being drained.
   assign load = !out_valid || out_ready;

   // Command FSM, address sweep, output register and running sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         busy      <= 1'b0;
         rom_addr  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         sum       <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (base_addr >= ADDR_W'(DEPTH)) begin
                     err <= 1'b1;
                  end else if (len == '0) begin
                     done <= 1'b1;
                     sum  <= '0;
                  end else begin
                     rom_addr  <= base_addr;
                     remaining <= len;
                     sum       <= '0;
                     busy      <= 1'b1;
                     state     <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (load) begin
                  out_data  <= rom_data;
                  out_valid <= 1'b1;
                  sum       <= acc_word(sum, rom_data);
                  rom_addr  <= next_addr(rom_addr);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     out_last <= 1'b1;
                     state    <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Self-checking bench for rom_seq_reader: directed scenarios plus randomized
// commands with random backpressure, checked against a list-based model.
module tb_rom_seq_reader;
   import rom_seq_reader_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  len = '0;
   logic              busy;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              done;
   logic              err;
   logic [SUM_W-1:0]  sum;

   int errors = 0;
   int checks = 0;

   // Observations gathered by the collector
   logic [DATA_W-1:0] obs_data[$];
   bit                obs_last[$];
   int first_valid_k, last_hs_k, done_k, stall_err, busy_err, timed_out;

   // Reference model results
   logic [DATA_W-1:0] exp_data[$];
   logic [SUM_W-1:0]  exp_sum;
   logic [ADDR_W-1:0] exp_end_addr;

   rom_seq_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .done      (done),
      .err       (err),
      .sum       (sum)
   );

   // ROM contents: word i holds 2*i
   always_comb rom_data = DATA_W'(rom_addr << 1);

   always #5 clk = ~clk;

   // Expected word list, final sum and final address for a sweep
   task automatic build_model(input int b, input int n);
      int tot;
      tot = 0;
      exp_data.delete();
      for (int i = 0; i < n; i++) begin
         int w;
         w = 2 * ((b + i) % DEPTH);
         exp_data.push_back(DATA_W'(w));
         tot += w;
      end
      exp_sum      = SUM_W'(tot);
      exp_end_addr = ADDR_W'((b + n) % DEPTH);
   endtask

   // Present a command for one clock edge (called and returns at a negedge)
   task automatic issue(input int b, input int n);
      start     = 1'b1;
      base_addr = ADDR_W'(b);
      len       = LEN_W'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drive out_ready each cycle and record handshakes until done or budget
   task automatic collect(input int rmode, input int inj_k, input int max_k);
      logic [DATA_W-1:0] held;
      bit stalled;
      stalled = 0;
      held = '0;
      obs_data.delete();
      obs_last.delete();
      first_valid_k = -1; last_hs_k = -1; done_k = -1;
      stall_err = 0; busy_err = 0; timed_out = 0;
      for (int k = 0; k < max_k; k++) begin
         if (done) begin
            done_k = k;
            break;
         end
         if (!busy) busy_err++;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (k % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (k == inj_k) begin
            start = 1'b1; base_addr = ADDR_W'(1); len = LEN_W'(2);
         end else begin
            start = 1'b0;
         end
         if (out_valid && first_valid_k < 0) first_valid_k = k;
         if (stalled && out_valid && out_data !== held) stall_err++;
         if (out_valid && out_ready) begin
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
            last_hs_k = k;
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
         @(negedge clk);
      end
      start = 1'b0;
      if (done_k < 0) timed_out = 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, rom_addr, out_valid, out_data, out_last, done, err, sum} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%0b addr=%0d vld=%0b data=%0d last=%0b done=%0b err=%0b sum=%0d, want all 0",
                  busy, rom_addr, out_valid, out_data, out_last, done, err, sum);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      build_model(2, 3);
      issue(2, 3);
      collect(0, -1, 50);
      checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
      checks++; if (first_valid_k != 1) begin errors++; $display("FAIL basic_latency: first valid at cycle %0d, want 1", first_valid_k); end
      checks++; if (obs_data.size() != 3) begin errors++; $display("FAIL basic_count: got %0d words, want 3", obs_data.size()); end
      for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 2)) begin
            errors++;
            $display("FAIL basic_word%0d: got data=%0d last=%0b, want data=%0d last=%0b", i, obs_data[i], obs_last[i], exp_data[i], i == 2);
         end
      end
      checks++; if (last_hs_k != 3) begin errors++; $display("FAIL basic_consecutive: last handshake at cycle %0d, want 3", last_hs_k); end
      checks++; if (done_k != last_hs_k + 1) begin errors++; $display("FAIL basic_done_timing: done at %0d, want %0d", done_k, last_hs_k + 1); end
      checks++; if (sum !== exp_sum || exp_sum !== SUM_W'(18)) begin errors++; $display("FAIL basic_sum: got %0d, want 18", sum); end
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%0b valid=%0b, want 0 0", busy, out_valid); end
   endtask

   task automatic test_wrap();
      build_model(6, 4);
      issue(6, 4);
      collect(0, -1, 50);
      checks++; if (timed_out != 0 || obs_data.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d words timeout=%0d, want 4 words", obs_data.size(), timed_out); end
      for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL wrap_word%0d: got %0d, want %0d", i, obs_data[i], exp_data[i]);
         end
      end
      checks++; if (sum !== SUM_W'(28)) begin errors++; $display("FAIL wrap_sum: got %0d, want 28", sum); end
      checks++; if (rom_addr !== exp_end_addr) begin errors++; $display("FAIL wrap_end_addr: got %0d, want %0d", rom_addr, exp_end_addr); end
   endtask

   task automatic test_backpressure();
      build_model(0, 4);
      issue(0, 4);
      collect(1, -1, 80);
      checks++; if (timed_out != 0 || obs_data.size() != 4) begin errors++; $display("FAIL bp_count: got %0d words timeout=%0d, want 4 words", obs_data.size(), timed_out); end
      for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL bp_word%0d: got data=%0d last=%0b, want data=%0d last=%0b", i, obs_data[i], obs_last[i], exp_data[i], i == 3);
         end
      end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_hold: out_data changed during %0d stalls, want 0", stall_err); end
      checks++; if (busy_err != 0) begin errors++; $display("FAIL bp_busy: busy low in %0d active cycles, want 0", busy_err); end
      checks++; if (sum !== SUM_W'(12)) begin errors++; $display("FAIL bp_sum: got %0d, want 12", sum); end
   endtask

   task automatic test_len_zero_and_err();
      issue(3, 0);
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || err !== 1'b0) begin
         errors++;
         $display("FAIL len0_pulse: done=%0b valid=%0b busy=%0b sum=%0d err=%0b, want 1 0 0 0 0", done, out_valid, busy, sum, err);
      end
      @(negedge clk);
      checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL len0_after: done=%0b valid=%0b, want 0 0", done, out_valid); end
      issue(9, 3);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse: err=%0b busy=%0b done=%0b, want 1 0 0", err, busy, done);
      end
      @(negedge clk);
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_after: err=%0b busy=%0b, want 0 0", err, busy); end
      issue(9, 0);
      checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL err_priority: err=%0b done=%0b, want 1 0", err, done); end
      @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      build_model(2, 3);
      issue(2, 3);
      collect(0, 1, 50);
      checks++; if (timed_out != 0 || obs_data.size() != 3) begin errors++; $display("FAIL busy_start_count: got %0d words timeout=%0d, want 3 words", obs_data.size(), timed_out); end
      for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL busy_start_word%0d: got %0d, want %0d", i, obs_data[i], exp_data[i]);
         end
      end
      checks++; if (sum !== exp_sum) begin errors++; $display("FAIL busy_start_sum: got %0d, want %0d", sum, exp_sum); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL busy_start_idle: busy=%0b valid=%0b, want 0 0", busy, out_valid); end
   endtask

   task automatic test_reset_mid();
      int cnt;
      cnt = 0;
      issue(0, 5);
      for (int k = 0; k < 30; k++) begin
         out_ready = 1'b1;
         if (out_valid) cnt++;
         if (cnt == 2) break;
         @(negedge clk);
      end
      checks++; if (cnt != 2) begin errors++; $display("FAIL rst_mid_progress: saw %0d words, want 2", cnt); end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, rom_addr, out_valid, out_data, out_last, done, err, sum} !== '0) begin
         errors++;
         $display("FAIL rst_mid_async: got busy=%0b addr=%0d vld=%0b data=%0d last=%0b done=%0b err=%0b sum=%0d, want all 0",
                  busy, rom_addr, out_valid, out_data, out_last, done, err, sum);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone: done=%0b busy=%0b valid=%0b, want 0 0 0", done, busy, out_valid); end
      build_model(3, 2);
      issue(3, 2);
      collect(0, -1, 50);
      checks++; if (timed_out != 0 || obs_data.size() != 2) begin errors++; $display("FAIL rst_mid_next_count: got %0d words timeout=%0d, want 2 words", obs_data.size(), timed_out); end
      for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
         checks++;
         if (obs_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL rst_mid_next_word%0d: got %0d, want %0d", i, obs_data[i], exp_data[i]);
         end
      end
      checks++; if (sum !== SUM_W'(14)) begin errors++; $display("FAIL rst_mid_next_sum: got %0d, want 14", sum); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 8; c++) begin
         int b, n;
         b = $urandom_range(0, DEPTH - 1);
         n = $urandom_range(1, 15);
         build_model(b, n);
         issue(b, n);
         collect(2, -1, 400);
         checks++;
         if (timed_out != 0 || obs_data.size() != n) begin
            errors++;
            $display("FAIL rand%0d_count: base=%0d len=%0d got %0d words timeout=%0d", c, b, n, obs_data.size(), timed_out);
         end
         for (int i = 0; i < n && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == n - 1)) begin
               errors++;
               $display("FAIL rand%0d_word%0d: got data=%0d last=%0b, want data=%0d last=%0b", c, i, obs_data[i], obs_last[i], exp_data[i], i == n - 1);
            end
         end
         checks++; if (sum !== exp_sum) begin errors++; $display("FAIL rand%0d_sum: got %0d, want %0d", c, sum, exp_sum); end
         checks++; if (stall_err != 0 || done_k != last_hs_k + 1) begin errors++; $display("FAIL rand%0d_timing: stall_err=%0d done_k=%0d last_hs=%0d", c, stall_err, done_k, last_hs_k); end
         checks++; if (rom_addr !== exp_end_addr) begin errors++; $display("FAIL rand%0d_end_addr: got %0d, want %0d", c, rom_addr, exp_end_addr); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero_and_err();
      test_wrap();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
